// File: rtl/mem_delayed_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_delayed_pkg
// Brief    : Request record and width constants shared by the delayed memory.
// Revision : 1.0
// ============================================================================
package mem_delayed_pkg;

    localparam int C_ADDR_W = 32;
    localparam int C_DATA_W = 32;
    localparam int C_LANES  = C_DATA_W / 8;
    localparam int C_CNT_W  = 8;

    typedef struct packed {
        logic                is_wr;
        logic [C_ADDR_W-1:0] addr;
        logic [C_DATA_W-1:0] data;
        logic [C_LANES-1:0]  strb;
        logic [C_CNT_W-1:0]  cnt;
    } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/mem_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_queue
// Brief    : In-order circular request FIFO with a per-entry latency countdown.
// Revision : 1.0
// ============================================================================
module mem_req_queue
    import mem_delayed_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ena,
    input  logic             i_push,
    input  mem_req_t         i_req,
    input  logic             i_pop,
    output mem_req_t         o_head,
    output logic             o_head_ready,
    output logic [CNT_W-1:0] o_count
);

    localparam int C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mem_req_t           r_slot [DEPTH];
    logic [DEPTH-1:0]   r_vld;
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    function automatic logic [C_PTR_W-1:0] f_next(input logic [C_PTR_W-1:0] p);
        return (p == C_PTR_W'(DEPTH - 1)) ? '0 : p + C_PTR_W'(1);
    endfunction

    // A freshly pushed slot is never valid, so load takes priority over countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_push && (r_wr_ptr == C_PTR_W'(i))) begin
                    r_slot[i] <= i_req;
                    r_vld[i]  <= 1'b1;
                end else begin
                    if (i_pop && (r_rd_ptr == C_PTR_W'(i))) begin
                        r_vld[i] <= 1'b0;
                    end
                    if (i_ena && r_vld[i] && (r_slot[i].cnt != '0)) begin
                        r_slot[i].cnt <= r_slot[i].cnt - C_CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= f_next(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head       = r_slot[r_rd_ptr];
    assign o_head_ready = r_vld[r_rd_ptr] && (r_slot[r_rd_ptr].cnt == '0);
    assign o_count      = r_count;

endmodule
`default_nettype wire

// File: rtl/mem_delayed_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : mem_delayed_pipelined
// Brief    : Behavioural main memory with fixed latency and in-order pipelined
//            requests; MEM_BYTE_STROBE_EN adds the wr_strb byte-enable port.
// Revision : 1.0
// ============================================================================
module mem_delayed_pipelined
    import mem_delayed_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH_WORDS     = 4096,
    parameter int LATENCY         = 5,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 ena,
    input  logic                                 rd_req,
    input  logic                                 wr_req,
    input  logic [ADDR_WIDTH-1:0]                addr,
    input  logic [DATA_WIDTH-1:0]                wr_data,
`ifdef MEM_BYTE_STROBE_EN
    input  logic [DATA_WIDTH/8-1:0]              wr_strb,
`endif
    output logic                                 busy,
    output logic                                 ack,
    output logic                                 ack_is_wr,
    output logic [DATA_WIDTH-1:0]                rd_data,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    input  logic                                 oob_wen,
    input  logic [ADDR_WIDTH-1:0]                oob_wr_addr,
    input  logic [DATA_WIDTH-1:0]                oob_wr_data
);

    localparam int C_IDX_W   = $clog2(DEPTH_WORDS);
    localparam int C_OCC_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int C_LANES_T = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

    mem_req_t               w_new_req;
    mem_req_t               w_head;
    logic                   w_head_ready;
    logic                   w_accept;
    logic                   w_complete;
    logic [C_OCC_W-1:0]     w_count;
    logic [C_LANES_T-1:0]   w_strb;
    logic [C_IDX_W-1:0]     w_head_idx;
    logic [C_IDX_W-1:0]     w_oob_idx;
    logic                   w_unused;

`ifdef MEM_BYTE_STROBE_EN
    assign w_strb = wr_strb;
`else
    assign w_strb = '1;
`endif

    // Full is judged on the registered count: a completing head does not free a slot this cycle.
    assign busy        = (w_count == C_OCC_W'(MAX_OUTSTANDING));
    assign outstanding = w_count;
    assign w_accept    = (rd_req | wr_req) & ~busy;
    assign w_complete  = ena & w_head_ready;
    assign w_head_idx  = w_head.addr[2 +: C_IDX_W];
    assign w_oob_idx   = oob_wr_addr[C_IDX_W-1:0];
    assign w_unused    = ^{w_head, oob_wr_addr};

    always_comb begin
        w_new_req       = '0;
        w_new_req.is_wr = wr_req;
        w_new_req.addr  = C_ADDR_W'(addr);
        w_new_req.data  = C_DATA_W'(wr_data);
        w_new_req.strb  = C_LANES'(w_strb);
        w_new_req.cnt   = C_CNT_W'(LATENCY - 1);
    end

    mem_req_queue #(
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (C_OCC_W)
    ) u_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_ena        (ena),
        .i_push       (w_accept),
        .i_req        (w_new_req),
        .i_pop        (w_complete),
        .o_head       (w_head),
        .o_head_ready (w_head_ready),
        .o_count      (w_count)
    );

    // Queued write is applied after the OOB write so it wins on a same-word collision.
    always_ff @(posedge clk) begin
        if (oob_wen) begin
            r_mem[w_oob_idx] <= oob_wr_data;
        end
        if (w_complete && w_head.is_wr) begin
            for (int b = 0; b < C_LANES_T; b++) begin
                if (w_head.strb[b]) begin
                    r_mem[w_head_idx][8*b +: 8] <= w_head.data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack       <= 1'b0;
            ack_is_wr <= 1'b0;
            rd_data   <= '0;
        end else begin
            ack       <= w_complete;
            ack_is_wr <= w_complete & w_head.is_wr;
            rd_data   <= (w_complete && !w_head.is_wr) ? r_mem[w_head_idx] : '0;
        end
    end

    assert_known : assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({rd_req, wr_req, ena, oob_wen}));

endmodule
`default_nettype wire

// File: tb/tb_mem_delayed_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_delayed_pipelined
// Brief    : Scoreboard bench for mem_delayed_pipelined (LATENCY=5, 4 outstanding).
// Revision : 1.0
// ============================================================================
module tb_mem_delayed_pipelined;

    localparam int LAT  = 5;
    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        rd_req;
    logic        wr_req;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        busy;
    logic        ack;
    logic        ack_is_wr;
    logic [31:0] rd_data;
    logic [2:0]  outstanding;
    logic        oob_wen;
    logic [31:0] oob_wr_addr;
    logic [31:0] oob_wr_data;

    always #5 clk = ~clk;

    mem_delayed_pipelined #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .DEPTH_WORDS     (4096),
        .LATENCY         (LAT),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .rd_req      (rd_req),
        .wr_req      (wr_req),
        .addr        (addr),
        .wr_data     (wr_data),
`ifdef MEM_BYTE_STROBE_EN
        .wr_strb     (wr_strb),
`endif
        .busy        (busy),
        .ack         (ack),
        .ack_is_wr   (ack_is_wr),
        .rd_data     (rd_data),
        .outstanding (outstanding),
        .oob_wen     (oob_wen),
        .oob_wr_addr (oob_wr_addr),
        .oob_wr_data (oob_wr_data)
    );

    typedef struct {
        logic        is_wr;
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cyc %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops one expectation per ack and checks kind, arrival cycle and read data.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (ack) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'(ack), 32'h0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("ack_is_wr", 32'(ack_is_wr), 32'(mon_e.is_wr));
                    chk("ack_cycle", 32'(cyc), 32'(mon_e.at));
                    if (!mon_e.is_wr) chk("rd_data", rd_data, mon_e.data);
                end
            end else begin
                chk("rd_data_idle", rd_data, 32'h0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic oob(input logic [31:0] a, input logic [31:0] d);
        oob_wen = 1'b1; oob_wr_addr = a; oob_wr_data = d;
        tick(1);
        oob_wen = 1'b0;
    endtask

    // extra = edges during which the request is frozen by ena=0
    task automatic issue(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic acc, input logic [31:0] exp_d, input int extra);
        wr_req = w; rd_req = r; addr = a; wr_data = d; wr_strb = s;
        tick(1);
        if (acc) sb.push_back('{is_wr: w, data: exp_d, at: cyc + LAT + extra});
        wr_req = 1'b0; rd_req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            tick(1);
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'h0);
            sb.delete();
        end
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; rd_req = 1'b0; wr_req = 1'b0; addr = '0;
        wr_data = '0; wr_strb = 4'hF; oob_wen = 1'b0; oob_wr_addr = '0; oob_wr_data = '0;
        tick(2);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_ack_is_wr", 32'(ack_is_wr), 32'h0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_outstanding", 32'(outstanding), 32'h0);
        rst_n = 1'b1;
        tick(1);

        // single read, plus address wrap and ignored low bits
        oob(32'd3, 32'hDEADBEEF);
        oob(32'h0000_1005, 32'h5555_AAAA);
        issue(1'b0, 1'b1, 32'd12, '0, 4'hF, 1'b1, 32'hDEADBEEF, 0);
        drain();
        issue(1'b0, 1'b1, 32'h0004_0017, '0, 4'hF, 1'b1, 32'h5555_AAAA, 0);
        drain();

        // four back-to-back reads fill the queue; fifth is dropped
        oob(32'd16, 32'h1000_0010);
        oob(32'd17, 32'h1000_0011);
        oob(32'd18, 32'h1000_0012);
        oob(32'd19, 32'h1000_0013);
        issue(1'b0, 1'b1, 32'd64, '0, 4'hF, 1'b1, 32'h1000_0010, 0);
        issue(1'b0, 1'b1, 32'd68, '0, 4'hF, 1'b1, 32'h1000_0011, 0);
        issue(1'b0, 1'b1, 32'd72, '0, 4'hF, 1'b1, 32'h1000_0012, 0);
        issue(1'b0, 1'b1, 32'd76, '0, 4'hF, 1'b1, 32'h1000_0013, 0);
        chk("full_busy", 32'(busy), 32'h1);
        chk("full_outstanding", 32'(outstanding), 32'd4);
        issue(1'b0, 1'b1, 32'd64, '0, 4'hF, 1'b0, '0, 0);
        drain();
        chk("idle_outstanding", 32'(outstanding), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);

        // write then read same word; simultaneous rd+wr is a write
        issue(1'b1, 1'b0, 32'd8, 32'h1234_5678, 4'hF, 1'b1, '0, 0);
        issue(1'b0, 1'b1, 32'd8, '0, 4'hF, 1'b1, 32'h1234_5678, 0);
        issue(1'b1, 1'b1, 32'd20, 32'hCAFE_F00D, 4'hF, 1'b1, '0, 0);
        issue(1'b0, 1'b1, 32'd20, '0, 4'hF, 1'b1, 32'hCAFE_F00D, 0);
        drain();

        // freeze two queued reads for ten edges
        issue(1'b0, 1'b1, 32'd12, '0, 4'hF, 1'b1, 32'hDEADBEEF, 10);
        issue(1'b0, 1'b1, 32'd64, '0, 4'hF, 1'b1, 32'h1000_0010, 10);
        ena = 1'b0;
        tick(10);
        chk("frozen_outstanding", 32'(outstanding), 32'd2);
        ena = 1'b1;
        drain();

        // queued write beats OOB write to the same word on the same edge
        issue(1'b1, 1'b0, 32'd28, 32'h7777_0000, 4'hF, 1'b1, '0, 0);
        tick(4);
        oob(32'd7, 32'hBAD0_0007);
        drain();
        issue(1'b0, 1'b1, 32'd28, '0, 4'hF, 1'b1, 32'h7777_0000, 0);
        drain();

        // async reset with three in flight
        issue(1'b0, 1'b1, 32'd12, '0, 4'hF, 1'b0, '0, 0);
        issue(1'b0, 1'b1, 32'd12, '0, 4'hF, 1'b0, '0, 0);
        issue(1'b0, 1'b1, 32'd12, '0, 4'hF, 1'b0, '0, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_outstanding", 32'(outstanding), 32'h0);
        chk("arst_ack", 32'(ack), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(12);
        chk("post_rst_outstanding", 32'(outstanding), 32'h0);
        issue(1'b0, 1'b1, 32'd12, '0, 4'hF, 1'b1, 32'hDEADBEEF, 0);
        drain();

`ifdef MEM_BYTE_STROBE_EN
        oob(32'd0, 32'hAABB_CCDD);
        issue(1'b1, 1'b0, 32'd0, 32'h1122_3344, 4'b0101, 1'b1, '0, 0);
        issue(1'b0, 1'b1, 32'd0, '0, 4'hF, 1'b1, 32'hAA22_CC44, 0);
        issue(1'b1, 1'b0, 32'd0, 32'hFFFF_FFFF, 4'b0000, 1'b1, '0, 0);
        issue(1'b0, 1'b1, 32'd0, '0, 4'hF, 1'b1, 32'hAA22_CC44, 0);
        drain();
`endif

        tick(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
